truth_table_probe: RTL and testbench

- Sequential characterizer for 3-input combinational logic blocks.
- Drives a target block's inputs (in1, in2, in3) through all 8 combinations and samples its single output after each one settles.
- Assembles the result into the 8-bit hex function code, the same code the team uses to name its 3-input gates (e.g. 0x75).
- Sits on the bench/emulation side of gate netlists; one instance per target gate.

---
 rtl/truth_table_probe_pkg.sv | 10 +
 rtl/truth_table_probe_sync2.sv | 12 +
 rtl/truth_table_probe.sv | 100 ++++++++++
 tb/tb_truth_table_probe.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_probe_pkg.sv
// truth_table_probe_pkg: shared FSM states, sizes and code bit mapping for the truth-table probe.
package truth_table_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  localparam int NUM_COMBOS = 8;
  localparam int CODE_W = 8;
  localparam int IDX_W = 3;
  function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] idx);
    return IDX_W'(NUM_COMBOS - 1) - idx;
  endfunction
endpackage

// File: rtl/truth_table_probe_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous bit, resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic r_meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, r_meta} <= 2'b00;
    else {q, r_meta} <= {r_meta, d};
endmodule

// File: rtl/truth_table_probe.sv
// truth_table_probe: sweeps a 3-input target through all inputs and builds its 8-bit function code.
// TRUTH_TABLE_PROBE_VOTE_EN: sample bit becomes a 2-of-3 vote over the last three cycles of each input.
module truth_table_probe
  import truth_table_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [IDX_W-1:0]  probe_in,
  input  logic              probe_out,
  output logic              busy,
  output logic              done,
  output logic [CODE_W-1:0] code,
  output logic              code_valid
);
  if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 2..255");
  end
  if (64'(SETTLE_CYCLES) > (64'd1 << CNT_W) - 64'd1) begin : g_bad_cnt
    $error("CNT_W too narrow for SETTLE_CYCLES");
  end
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  logic w_sync;
  logic w_bit;
  state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(probe_out), .q(w_sync));
`ifdef TRUTH_TABLE_PROBE_VOTE_EN
  if (SETTLE_CYCLES < 4) begin : g_bad_vote
    $error("voting needs SETTLE_CYCLES >= 4");
  end
  logic [1:0] r_hist;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_hist <= 2'b00;
    else r_hist <= {r_hist[0], w_sync};
  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_sync) | (r_hist[0] & w_sync);
`else
  assign w_bit = w_sync;
`endif
  // abort outranks every transition, including a start seen in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      probe_in   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      code       <= '0;
      code_valid <= 1'b0;
    end else if (abort) begin
      r_state    <= IDLE;
      probe_in   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      code_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state    <= SETTLE;
          r_idx      <= '0;
          probe_in   <= '0;
          r_cnt      <= RELOAD;
          busy       <= 1'b1;
          code_valid <= 1'b0;
          code       <= '0;
        end
        SETTLE: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= SAMPLE;
        end
        SAMPLE: begin
          code[bit_pos(r_idx)] <= w_bit;
          if (r_idx == IDX_W'(NUM_COMBOS - 1)) begin
            r_state    <= DONE;
            probe_in   <= '0;
            busy       <= 1'b0;
            done       <= 1'b1;
            code_valid <= 1'b1;
          end else begin
            r_state  <= SETTLE;
            r_idx    <= r_idx + 1'b1;
            probe_in <= r_idx + 1'b1;
            r_cnt    <= RELOAD;
          end
        end
        DONE: begin
          r_state <= IDLE;
          done    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_probe.sv
// tb_truth_table_probe: randomized and directed sweeps checked every cycle against a timing/arithmetic model.
module tb_truth_table_probe;
  localparam int S = 4;
  localparam int P = S + 1;
  localparam int SWEEP = 8 * P;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic glitch = 1'b0;
  logic [2:0] probe_in;
  logic probe_out, busy, done, code_valid;
  logic [7:0] code;
  int mode = 0;
  logic [7:0] rtab = 8'h00;
  logic [7:0] flip = 8'h00;
  int checks = 0, errors = 0;
  int edge_n = 0, t0 = 0, done_cnt = 0, last_done = 0;
  bit have = 0, m_valid = 0;
  logic [7:0] m_code = 8'h00;

  always #5 clk = ~clk;

  truth_table_probe #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .probe_in(probe_in), .probe_out(probe_out), .busy(busy), .done(done),
    .code(code), .code_valid(code_valid)
  );

  function automatic logic tgt(input int md, input logic [2:0] v, input logic [7:0] tab);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    case (md)
      0: return c | (b & ~a);
      1: return 1'b1;
      2: return 1'b0;
      3: return a ^ b ^ c;
      4: return a & b & c;
      default: return tab[v];
    endcase
  endfunction

  assign probe_out = tgt(mode, probe_in, rtab) ^ glitch;

  function automatic logic [7:0] full_code();
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 8; i++) c[7-i] = tgt(mode, 3'(i), rtab) ^ flip[7-i];
    return c;
  endfunction

  function automatic logic [7:0] partial(input int j);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++) if (P * i + P <= j) m[7-i] = 1'b1;
    return full_code() & m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have <= 0; m_valid <= 0; m_code <= 8'h00;
    end else begin
      int jp;
      bit sw;
      jp = edge_n - t0;
      sw = have && jp >= 0 && jp <= SWEEP;
      edge_n <= edge_n + 1;
      if (abort) begin
        have <= 0; m_valid <= 0;
        if (sw) m_code <= partial(jp);
      end else if (sw && jp == SWEEP) begin
        have <= 0; m_valid <= 1; m_code <= full_code();
      end else if (!sw && start) begin
        have <= 1; t0 <= edge_n + 1; m_valid <= 0; m_code <= 8'h00;
      end
    end
  end

  always @(negedge clk) begin
    int j;
    bit sw;
    logic [2:0] ep;
    logic eb, ed, ev;
    logic [7:0] ec;
    j = edge_n - t0;
    sw = have && j >= 0 && j <= SWEEP;
    ep = 3'd0; eb = 0; ed = 0; ev = m_valid; ec = m_code;
    if (sw && j < SWEEP) begin
      ep = 3'(j / P); eb = 1; ev = 0; ec = partial(j);
    end else if (sw) begin
      ed = 1; ev = 1; ec = full_code();
    end
    chk("probe_in", 32'(probe_in), 32'(ep));
    chk("busy", 32'(busy), 32'(eb));
    chk("done", 32'(done), 32'(ed));
    chk("code_valid", 32'(code_valid), 32'(ev));
    chk("code", 32'(code), 32'(ec));
    if (done) begin done_cnt++; last_done = edge_n; end
  end

  task automatic sweep(input logic [7:0] exp_code, input string nm, input bit noise, input bit glt);
    int ps, n0, k;
    n0 = done_cnt;
    @(posedge clk); #1 start = 1;
    @(negedge clk); ps = edge_n;
    @(posedge clk); #1 start = 0;
    chk({nm, "_busy_after_start"}, 32'(busy), 32'd1);
    chk({nm, "_valid_dropped"}, 32'(code_valid), 32'd0);
    if (noise) begin
      repeat (3) begin
        repeat (9) @(posedge clk);
        #1 start = 1;
        @(posedge clk); #1 start = 0;
      end
      while (edge_n < ps + SWEEP) @(negedge clk);
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
    end
    if (glt) begin
      while (edge_n < ps + 17) @(negedge clk);
      @(posedge clk); #1 glitch = 1;
      @(posedge clk); #1 glitch = 0;
    end
    k = 0;
    while (done_cnt == n0 && k < 100) begin @(negedge clk); #1; k++; end
    chk({nm, "_done_seen"}, 32'(done_cnt - n0), 32'd1);
    chk({nm, "_latency"}, 32'(last_done - ps), 32'd41);
    chk({nm, "_code"}, 32'(code), 32'(exp_code));
    chk({nm, "_valid"}, 32'(code_valid), 32'd1);
    if (noise) begin
      repeat (6) @(negedge clk);
      chk({nm, "_single_done"}, 32'(done_cnt - n0), 32'd1);
      chk({nm, "_no_restart"}, 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int k, n0;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_probe", 32'(probe_in), 32'd0);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_valid", 32'(code_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    mode = 0;
    chk("model_pin_75", 32'(full_code()), 32'h75);
    sweep(8'h75, "andor", 0, 0);
    mode = 1; sweep(8'hFF, "const1", 0, 0);
    mode = 2; sweep(8'h00, "const0", 0, 0);
    mode = 3;
    chk("model_pin_69", 32'(full_code()), 32'h69);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    k = 0;
    while (probe_in !== 3'd4 && k < 60) begin @(negedge clk); k++; end
    chk("abort_reach_idx4", 32'(probe_in), 32'd4);
    n0 = done_cnt;
    @(posedge clk); #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_probe", 32'(probe_in), 32'd0);
    chk("abort_valid", 32'(code_valid), 32'd0);
    repeat (50) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - n0), 32'd0);
    @(posedge clk); #1 start = 1; abort = 1;
    @(posedge clk); #1 start = 0; abort = 0;
    chk("start_abort_idle", 32'(busy), 32'd0);
    sweep(8'h69, "xor", 0, 0);
    mode = 0; sweep(8'h75, "noise", 1, 0);
    mode = 3;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    repeat (13) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("arst_probe", 32'(probe_in), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_code", 32'(code), 32'd0);
    chk("arst_valid", 32'(code_valid), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(posedge clk); #1 rst_n = 1;
    mode = 5; rtab = 8'($urandom);
    sweep(full_code(), "post_rst", 0, 0);
    mode = 4;
`ifdef TRUTH_TABLE_PROBE_VOTE_EN
    flip = 8'h00;
    sweep(8'h01, "glitch", 0, 1);
`else
    flip = 8'h10;
    sweep(8'h11, "glitch", 0, 1);
`endif
    flip = 8'h00;
    for (int r = 0; r < 4; r++) begin
      mode = 5; rtab = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      sweep(full_code(), "random", 0, 0);
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
